// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared definitions for the ADC frame capture sequencer:
//   - cap_state_e    : sequencer state encoding (visible on state_o)
//   - DEF_LEN_W      : default width of frame-length / sample counters
//   - DEF_NFR_W      : default width of frame-count config / counter
//   - MAX_LAST_DELAY : deepest converter latency the tlast pipeline supports
// -----------------------------------------------------------------------------
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam int DEF_LEN_W      = 16;
    localparam int DEF_NFR_W      = 8;
    localparam int MAX_LAST_DELAY = 19;

endpackage : adc_capture_pkg

// File: rtl/adc_level_trigger.sv
// -----------------------------------------------------------------------------
// adc_level_trigger
// Signed threshold-crossing detector between consecutive valid samples.
// Only built when LEVEL_TRIG_EN is defined.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : high while the sequencer is ARMED; low forgets the
//                   previous sample so a crossing never spans an ARMED entry
//   sample        : current ADC sample (signed)
//   sample_valid  : sample strobe
//   level         : signed threshold
//   rising        : 1 = prev < level <= cur, 0 = prev > level >= cur
//   trig          : single-cycle pulse on the crossing sample itself
// -----------------------------------------------------------------------------
module adc_level_trigger #(
    parameter int ADC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic signed [ADC_WIDTH-1:0] sample,
    input  logic                        sample_valid,
    input  logic signed [ADC_WIDTH-1:0] level,
    input  logic                        rising,
    output logic                        trig
);

    logic signed [ADC_WIDTH-1:0] prev;
    logic                        prev_valid;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order; blocking here would
    // create order-dependent simulation and mismatch the synthesized netlist.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (!enable) begin
            prev_valid <= 1'b0;
        end else if (sample_valid) begin
            prev       <= sample;
            prev_valid <= 1'b1;
        end
    end

    // Combinational so the sequencer reacts on the crossing sample; the
    // sample after the crossing is then the first one captured.
    // NOTE: trig gets a default before any branch, otherwise paths that do
    // not assign it would infer a latch.
    always_comb begin
        trig = 1'b0;
        if (enable && sample_valid && prev_valid) begin
            if (rising) trig = (prev < level) && (level <= sample);
            else        trig = (prev > level) && (level >= sample);
        end
    end

endmodule : adc_level_trigger

// File: rtl/adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_capture_ctrl
// Frame capture sequencer between the ADC sample source and the ADC-to-AXIS
// packing converter. Arms on request, waits for a trigger, passes exactly
// cfg_frame_len valid samples per frame for cfg_num_frames frames, and builds
// a tlast aligned to the converter's delayed tvalid. Since the converter has
// no tready, lost beats are only reported through the sticky overflow flag.
//
// Build option: LEVEL_TRIG_EN adds trig_level / trig_rising and a signed
// threshold-crossing trigger ORed with sw_trig.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   arm, abort       : session start (IDLE/DONE only) / return to IDLE
//   sw_trig          : software trigger
//   cfg_frame_len    : samples per frame (0 treated as 1), latched on arm
//   cfg_num_frames   : frames per session (0 = unlimited), latched on arm
//   adc_data_in/valid: raw sample stream
//   gate_data/valid  : gated, registered stream to the converter
//   m_tlast          : end of frame at the converter's output stage
//   m_tready         : downstream ready, observed at the aligned stage
//   state_o          : 0=IDLE 1=ARMED 2=CAPTURE 3=DONE
//   frames_done      : completed frames this session (saturating)
//   overflow         : sticky, aligned beat seen while m_tready was low
//   aborted          : sticky, abort landed in the middle of a frame
// -----------------------------------------------------------------------------
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int ADC_WIDTH  = 16,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int NFR_W      = DEF_NFR_W,
    parameter int LAST_DELAY = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm,
    input  logic                        abort,
    input  logic                        sw_trig,
    input  logic [LEN_W-1:0]            cfg_frame_len,
    input  logic [NFR_W-1:0]            cfg_num_frames,
    input  logic [ADC_WIDTH-1:0]        adc_data_in,
    input  logic                        adc_data_valid,
`ifdef LEVEL_TRIG_EN
    input  logic signed [ADC_WIDTH-1:0] trig_level,
    input  logic                        trig_rising,
`endif
    output logic [ADC_WIDTH-1:0]        gate_data,
    output logic                        gate_valid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [1:0]                  state_o,
    output logic [NFR_W-1:0]            frames_done,
    output logic                        overflow,
    output logic                        aborted
);

    cap_state_e              state;
    logic [LEN_W-1:0]        len_q;
    logic [NFR_W-1:0]        nfr_q;
    logic [LEN_W-1:0]        sample_cnt;
    logic                    last_int;
    logic [LAST_DELAY-1:0]   last_pipe;
    logic [LAST_DELAY-1:0]   valid_pipe;
    logic                    v_al;

    logic                    trig;
    logic                    pass;
    logic                    frame_end;
    logic                    session_end;

`ifdef LEVEL_TRIG_EN
    logic lvl_trig;

    adc_level_trigger #(
        .ADC_WIDTH (ADC_WIDTH)
    ) u_level_trigger (
        .clk          (clk),
        .rst          (rst),
        .enable       (state == ST_ARMED),
        .sample       (adc_data_in),
        .sample_valid (adc_data_valid),
        .level        (trig_level),
        .rising       (trig_rising),
        .trig         (lvl_trig)
    );

    assign trig = sw_trig | lvl_trig;
`else
    assign trig = sw_trig;
`endif

    // Abort takes priority, so a sample in the abort cycle is never passed.
    // frames_done + 1 cannot wrap before matching a nonzero nfr_q, because
    // reaching nfr_q ends the session.
    always_comb begin
        pass        = (state == ST_CAPTURE) && adc_data_valid && !abort;
        frame_end   = pass && (sample_cnt == len_q - LEN_W'(1));
        session_end = frame_end && (nfr_q != '0) &&
                      (frames_done + NFR_W'(1) == nfr_q);
    end

    assign state_o = state;
    assign m_tlast = last_pipe[LAST_DELAY-1];
    assign v_al    = valid_pipe[LAST_DELAY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            nfr_q       <= '0;
            sample_cnt  <= '0;
            frames_done <= '0;
            overflow    <= 1'b0;
            aborted     <= 1'b0;
            gate_data   <= '0;
            gate_valid  <= 1'b0;
            last_int    <= 1'b0;
            // NOTE: the delay pipeline is a small flop shift register, not a
            // RAM, so it is reset; a stale tlast after reset would corrupt
            // the first downstream frame.
            last_pipe   <= '0;
            valid_pipe  <= '0;
        end else begin
            gate_valid <= pass;
            last_int   <= frame_end;
            if (pass) gate_data <= adc_data_in;

            // Never flushed by abort: frames already in flight complete.
            last_pipe[0]  <= last_int;
            valid_pipe[0] <= gate_valid;
            for (int i = 1; i < LAST_DELAY; i++) begin
                last_pipe[i]  <= last_pipe[i-1];
                valid_pipe[i] <= valid_pipe[i-1];
            end

            if (abort) begin
                if (state == ST_CAPTURE && sample_cnt != '0) aborted <= 1'b1;
                state       <= ST_IDLE;
                sample_cnt  <= '0;
                frames_done <= '0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            len_q       <= (cfg_frame_len == '0) ? LEN_W'(1)
                                                                 : cfg_frame_len;
                            nfr_q       <= cfg_num_frames;
                            sample_cnt  <= '0;
                            frames_done <= '0;
                            overflow    <= 1'b0;
                            aborted     <= 1'b0;
                            state       <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig) state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        if (frame_end) begin
                            sample_cnt <= '0;
                            if (frames_done != '1)
                                frames_done <= frames_done + NFR_W'(1);
                            state <= session_end ? ST_DONE : ST_ARMED;
                        end else if (pass) begin
                            sample_cnt <= sample_cnt + LEN_W'(1);
                        end
                    end
                endcase
            end

            // Placed after the arm clear: a lost beat in the arm cycle is kept.
            if (v_al && !m_tready) overflow <= 1'b1;
        end
    end

endmodule : adc_capture_ctrl

// File: tb/tb_adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_ctrl
// Self-checking bench: a behavioural model predicts every output each cycle
// from the capture rules; directed scenarios pin the model with literal
// expectations, then a randomized phase stresses arm/abort/trigger/reset.
// -----------------------------------------------------------------------------
module tb_adc_capture_ctrl;

    localparam int ADC_WIDTH  = 16;
    localparam int LEN_W      = 16;
    localparam int NFR_W      = 8;
    localparam int LAST_DELAY = 3;

    localparam int S_IDLE = 0, S_ARMED = 1, S_CAPT = 2, S_DONE = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 arm = 1'b0;
    logic                 abort = 1'b0;
    logic                 sw_trig = 1'b0;
    logic [LEN_W-1:0]     cfg_frame_len = '0;
    logic [NFR_W-1:0]     cfg_num_frames = '0;
    logic [ADC_WIDTH-1:0] adc_data_in = '0;
    logic                 adc_data_valid = 1'b0;
    logic                 m_tready = 1'b1;
`ifdef LEVEL_TRIG_EN
    logic signed [ADC_WIDTH-1:0] trig_level = '0;
    logic                        trig_rising = 1'b1;
`endif
    logic [ADC_WIDTH-1:0] gate_data;
    logic                 gate_valid;
    logic                 m_tlast;
    logic [1:0]           state_o;
    logic [NFR_W-1:0]     frames_done;
    logic                 overflow;
    logic                 aborted;

    adc_capture_ctrl #(
        .ADC_WIDTH  (ADC_WIDTH),
        .LEN_W      (LEN_W),
        .NFR_W      (NFR_W),
        .LAST_DELAY (LAST_DELAY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .abort          (abort),
        .sw_trig        (sw_trig),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_num_frames (cfg_num_frames),
        .adc_data_in    (adc_data_in),
        .adc_data_valid (adc_data_valid),
`ifdef LEVEL_TRIG_EN
        .trig_level     (trig_level),
        .trig_rising    (trig_rising),
`endif
        .gate_data      (gate_data),
        .gate_valid     (gate_valid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .state_o        (state_o),
        .frames_done    (frames_done),
        .overflow       (overflow),
        .aborted        (aborted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Beats and frame ends are scheduled on a timeline indexed by the clock
    // edge at which they must appear at the converter's output stage.
    int                   cyc_n = 0;
    bit                   model_on = 1'b0;
    int                   m_state = S_IDLE;
    int                   m_taken = 0;       // samples taken in current frame
    int                   m_len = 1;
    int                   m_nfr = 0;
    int                   m_frames = 0;
    bit                   m_ovf = 1'b0;
    bit                   m_abt = 1'b0;
    bit                   m_gv = 1'b0;
    logic [ADC_WIDTH-1:0] m_gd = '0;
    bit                   al_v    [64];
    bit                   al_last [64];
    bit                   have_prev = 1'b0;
    logic signed [ADC_WIDTH-1:0] prev_s = '0;

    always @(posedge clk) begin : model
        bit take, last, fire, lost;
        logic signed [ADC_WIDTH-1:0] cur;
        cyc_n++;
        lost = al_v[(cyc_n - 1) % 64] && !m_tready;
        if (rst) begin
            model_on = 1'b1;
            m_state = S_IDLE; m_taken = 0; m_len = 1; m_nfr = 0; m_frames = 0;
            m_ovf = 1'b0; m_abt = 1'b0; m_gv = 1'b0; have_prev = 1'b0;
            for (int k = 0; k <= LAST_DELAY; k++) begin
                al_v[(cyc_n + k) % 64]    = 1'b0;
                al_last[(cyc_n + k) % 64] = 1'b0;
            end
        end else begin
            take = (m_state == S_CAPT) && adc_data_valid && !abort;
            last = take && (m_taken + 1 >= m_len);
            fire = sw_trig;
            cur  = $signed(adc_data_in);
`ifdef LEVEL_TRIG_EN
            if (m_state == S_ARMED && adc_data_valid && have_prev) begin
                if (trig_rising) fire |= (prev_s < trig_level) && (trig_level <= cur);
                else             fire |= (prev_s > trig_level) && (trig_level >= cur);
            end
`endif
            if (m_state != S_ARMED) have_prev = 1'b0;
            else if (adc_data_valid) begin prev_s = cur; have_prev = 1'b1; end

            m_gv = take;
            if (take) m_gd = adc_data_in;
            al_v[(cyc_n + LAST_DELAY) % 64]    = take;
            al_last[(cyc_n + LAST_DELAY) % 64] = last;

            if (abort) begin
                if (m_state == S_CAPT && m_taken > 0) m_abt = 1'b1;
                m_state = S_IDLE; m_taken = 0; m_frames = 0;
            end else if ((m_state == S_IDLE || m_state == S_DONE) && arm) begin
                m_len = (cfg_frame_len == 0) ? 1 : int'(cfg_frame_len);
                m_nfr = int'(cfg_num_frames);
                m_taken = 0; m_frames = 0; m_ovf = 1'b0; m_abt = 1'b0;
                m_state = S_ARMED;
            end else if (m_state == S_ARMED && fire) begin
                m_state = S_CAPT;
            end else if (take) begin
                if (last) begin
                    m_taken = 0;
                    if (m_frames < 255) m_frames++;
                    m_state = (m_nfr != 0 && m_frames == m_nfr) ? S_DONE : S_ARMED;
                end else begin
                    m_taken++;
                end
            end
            if (lost) m_ovf = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    int n_gv = 0, n_tl = 0, gv_cyc = 0, tl_cyc = 0;

    always @(negedge clk) begin
        if (model_on) begin
            check("state_o", state_o, m_state);
            check("frames_done", frames_done, m_frames);
            check("overflow", overflow, m_ovf);
            check("aborted", aborted, m_abt);
            check("gate_valid", gate_valid, m_gv);
            if (m_gv) check("gate_data", gate_data, m_gd);
            check("m_tlast", m_tlast, al_last[cyc_n % 64]);
            if (gate_valid === 1'b1) begin n_gv++; gv_cyc = cyc_n; end
            if (m_tlast === 1'b1)    begin n_tl++; tl_cyc = cyc_n; end
        end
    end

    // ---------------- stimulus helpers ----------------
    // vmode: 0 continuous, 1 every 3rd cycle, 2 random, 3 off, 4 manual
    int vmode = 3;
    int tick  = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        tick++;
        case (vmode)
            0: begin adc_data_valid = 1'b1; adc_data_in = ADC_WIDTH'($urandom); end
            1: begin adc_data_valid = (tick % 3 == 0); adc_data_in = ADC_WIDTH'($urandom); end
            2: begin adc_data_valid = ($urandom_range(0, 9) < 6); adc_data_in = ADC_WIDTH'($urandom); end
            3: adc_data_valid = 1'b0;
            default: ;
        endcase
    endtask

    task automatic pulse_arm(input int len, input int nfr);
        cfg_frame_len  = LEN_W'(len);
        cfg_num_frames = NFR_W'(nfr);
        arm = 1'b1; cyc(); arm = 1'b0;
    endtask

    task automatic pulse_trig();
        sw_trig = 1'b1; cyc(); sw_trig = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; cyc(); abort = 1'b0;
    endtask

    task automatic wait_frame_end(input int budget);
        int k = 0;
        while (state_o == 2'd2 && k < budget) begin cyc(); k++; end
        check("frame_end_reached", {31'd0, state_o != 2'd2}, 1);
    endtask

    task automatic clear_counts();
        n_gv = 0; n_tl = 0; gv_cyc = 0; tl_cyc = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_state", state_o, 0);
        check("rst_gate_valid", gate_valid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_frames", frames_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_aborted", aborted, 0);

        // Single frame, continuous valid.
        vmode = 0; clear_counts();
        pulse_arm(8, 1);
        pulse_trig();
        wait_frame_end(30);
        repeat (LAST_DELAY + 3) cyc();
        check("single_gv_count", n_gv, 8);
        check("single_tlast_count", n_tl, 1);
        check("single_tlast_delay", tl_cyc - gv_cyc, 3);
        check("single_state", state_o, 3);
        check("single_frames", frames_done, 1);

        // Multi-frame, sparse valid, one trigger per frame.
        vmode = 1; clear_counts();
        pulse_arm(4, 3);
        for (int f = 0; f < 3; f++) begin
            pulse_trig();
            wait_frame_end(60);
            check("multi_between_state", state_o, (f < 2) ? 1 : 3);
        end
        repeat (LAST_DELAY + 3) cyc();
        check("multi_gv_count", n_gv, 12);
        check("multi_tlast_count", n_tl, 3);
        check("multi_frames", frames_done, 3);

        // Abort mid-frame.
        vmode = 0; clear_counts();
        pulse_arm(10, 1);
        pulse_trig();
        for (int k = 0; k < 40 && n_gv < 5; k++) cyc();
        pulse_abort();
        check("abort_state", state_o, 0);
        check("abort_flag", aborted, 1);
        check("abort_gate_valid", gate_valid, 0);
        repeat (LAST_DELAY + 6) cyc();
        check("abort_no_tlast", n_tl, 0);
        pulse_arm(4, 1);
        check("abort_cleared_by_arm", aborted, 0);
        pulse_abort();

        // Backpressure at the aligned stage.
        pulse_arm(4, 2);
        pulse_trig();
        begin
            int k = 0;
            while (m_tlast !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        end
        check("bp_tlast_seen", m_tlast, 1);
        m_tready = 1'b0;
        @(posedge clk); #1;
        m_tready = 1'b1;
        check("bp_overflow_set", overflow, 1);
        pulse_trig();
        wait_frame_end(30);
        repeat (LAST_DELAY + 3) cyc();
        check("bp_overflow_sticky", overflow, 1);
        check("bp_done", state_o, 3);
        pulse_arm(4, 1);
        check("bp_overflow_cleared", overflow, 0);
        pulse_abort();

        // len = 0 behaves as one-sample frames.
        clear_counts();
        pulse_arm(0, 2);
        pulse_trig(); wait_frame_end(10);
        pulse_trig(); wait_frame_end(10);
        repeat (LAST_DELAY + 3) cyc();
        check("len0_gv_count", n_gv, 2);
        check("len0_tlast_count", n_tl, 2);
        check("len0_state", state_o, 3);

        // frames = 0 never finishes.
        pulse_arm(2, 0);
        for (int f = 0; f < 5; f++) begin
            pulse_trig();
            wait_frame_end(10);
            check("unlim_state", state_o, 1);
        end
        check("unlim_frames", frames_done, 5);
        pulse_abort();
        check("unlim_abort_frames", frames_done, 0);

        // arm with sw_trig in the same cycle: trigger ignored.
        cfg_frame_len = 4; cfg_num_frames = 1;
        arm = 1'b1; sw_trig = 1'b1; cyc(); arm = 1'b0; sw_trig = 1'b0;
        repeat (3) cyc();
        check("arm_trig_same_cycle", state_o, 1);
        pulse_abort();

`ifdef LEVEL_TRIG_EN
        // Rising level trigger at 100 on 50, 99, 100, 120.
        vmode = 3; trig_level = 16'sd100; trig_rising = 1'b1;
        pulse_arm(1, 1);
        vmode = 4;
        adc_data_valid = 1'b1;
        adc_data_in = 16'd50;  cyc();
        adc_data_in = 16'd99;  cyc();
        check("lvl_no_trig_99", state_o, 1);
        adc_data_in = 16'd100; cyc();
        check("lvl_trig_on_100", state_o, 2);
        adc_data_in = 16'd120; cyc();
        adc_data_valid = 1'b0;
        check("lvl_first_valid", gate_valid, 1);
        check("lvl_first_data", gate_data, 120);
        cyc();
        check("lvl_done", state_o, 3);
`endif

        // Randomized phase.
        vmode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 999) == 0);
            arm            = ($urandom_range(0, 29) == 0);
            abort          = ($urandom_range(0, 149) == 0);
            sw_trig        = ($urandom_range(0, 5) == 0);
            m_tready       = ($urandom_range(0, 19) != 0);
            cfg_frame_len  = LEN_W'($urandom_range(0, 6));
            cfg_num_frames = NFR_W'($urandom_range(0, 4));
`ifdef LEVEL_TRIG_EN
            if (arm) begin
                trig_level  = ADC_WIDTH'($urandom);
                trig_rising = 1'($urandom_range(0, 1));
            end
`endif
            cyc();
        end
        rst = 1'b0; arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; m_tready = 1'b1;
        vmode = 3;
        repeat (LAST_DELAY + 3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adc_capture_ctrl

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Frame capture sequencer that sits between the ADC sample source and the ADC-to-AXIS packing converter.
- Arms on request, waits for a trigger, then passes exactly cfg_frame_len valid samples downstream per frame, for cfg_num_frames frames.
- Generates a tlast aligned to the converter's delayed tvalid.
- Flags downstream backpressure loss, because the converter has no tready.

Parameters:
ADC_WIDTH, 16, ADC sample width
LEN_W, 16, width of frame-length and sample counters
NFR_W, 8, width of frame-count config and counter
LAST_DELAY, 3, cycles from gate_valid to the converter's output tvalid; tlast is delayed by this amount (1..19)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
arm  in  1  pulse; start a capture session (accepted only in IDLE or DONE)
abort  in  1  pulse; return to IDLE from any state
sw_trig  in  1  software trigger pulse
cfg_frame_len  in  LEN_W  samples per frame; sampled on accepted arm
cfg_num_frames  in  NFR_W  frames per session; 0 = unlimited; sampled on accepted arm
adc_data_in  in  ADC_WIDTH  raw ADC sample
adc_data_valid  in  1  sample strobe
gate_data  out  ADC_WIDTH  registered sample to the converter
gate_valid  out  1  gated sample strobe to the converter
m_tlast  out  1  end of frame, aligned to the converter's output tvalid
m_tready  in  1  downstream ready, observed at the aligned stage
state_o  out  2  0=IDLE 1=ARMED 2=CAPTURE 3=DONE
frames_done  out  NFR_W  completed frames this session
overflow  out  1  sticky: an aligned valid occurred while m_tready=0
aborted  out  1  sticky: abort hit CAPTURE mid-frame

Behaviour:
- Reset: state IDLE. All outputs 0, the delay pipeline cleared, and all counters 0.
- IDLE/DONE + arm:
  - latch cfg values; cfg_frame_len=0 is latched as 1;
  - clear frames_done, overflow and aborted;
  - go to ARMED on the next cycle.
- arm in ARMED/CAPTURE is ignored. arm and abort in the same cycle: abort wins.
- ARMED + trigger (sw_trig, or the level trigger when enabled) -> CAPTURE next cycle. A trigger in the same cycle as the accepting arm is ignored.
- CAPTURE sample passing:
  - gate_data and gate_valid are registered copies of adc_data_in and adc_data_valid; latency 1 cycle.
  - gate_valid is 0 in every other state.
  - The sample coincident with the trigger is not passed.
- sample_cnt counts passed samples. On the sample where sample_cnt == len-1:
  - last_int=1 on that sample;
  - sample_cnt -> 0;
  - frames_done increments, saturating at the maximum value;
  - if frames_done+1 == num_frames (num_frames != 0) go to DONE, else return to ARMED. Each frame needs a new trigger.
- A trigger arriving during CAPTURE is ignored.
- last_int passes through a LAST_DELAY-stage shift register to form m_tlast. A valid shift register of equal depth forms v_al.
- overflow sets when v_al=1 and m_tready=0. It is cleared only by an accepted arm or by rst.
- abort from any state -> IDLE next cycle and gate_valid=0.
  - If abort hits CAPTURE with sample_cnt != 0, aborted=1; no tlast is emitted for the partial frame.
  - The delay pipelines are not flushed, so frames already in flight complete.
- DONE holds frames_done until the next arm or abort.

Optional Feature:
LEVEL_TRIG_EN
- Defined:
  - adds input trig_level [ADC_WIDTH] (signed) and input trig_rising [1];
  - in ARMED, a trigger fires on a signed threshold crossing between consecutive valid samples (prev < level <= cur for rising; prev > level >= cur for falling);
  - this trigger is ORed with sw_trig;
  - prev is invalidated on entry to ARMED.
- Undefined: ports absent; sw_trig only.

Decomposition:
- Package adc_capture_pkg: state encoding constants (IDLE..DONE), default LEN_W/NFR_W, and the maximum LAST_DELAY of 19.
- Sub-module adc_level_trigger: holds previous sample, performs the compare, outputs a 1-cycle pulse; instantiated only under LEVEL_TRIG_EN.

Test Plan:
- Single frame: len=8, frames=1, continuous valid, m_tready=1, arm, sw_trig.
  - Exactly 8 gate_valid pulses.
  - m_tlast on the 8th, LAST_DELAY=3 cycles after its gate_valid.
  - state=DONE, frames_done=1.
- Multi-frame with sparse valid: len=4, frames=3, valid every 3rd cycle, three triggers.
  - 12 samples in total, 3 tlasts.
  - Between frames state returns to ARMED and gate_valid=0.
- Abort mid-frame: len=10, abort after 5 samples.
  - IDLE next cycle, aborted=1, no tlast.
  - A subsequent arm clears aborted.
- Backpressure: m_tready=0 for one cycle while v_al=1.
  - overflow=1 and stays 1 until the next arm.
- Edge configs:
  - len=0: every frame is one sample with tlast.
  - frames=0: ARMED/CAPTURE cycles indefinitely.
  - arm and sw_trig in the same cycle: stays ARMED.
- LEVEL_TRIG_EN, rising, level=100: sample sequence 50, 99, 100, 120.
  - Trigger on 100; capture starts with 120.
